// File: rtl/hdb3_pkg.sv
// Shared HDB3 line-code definitions: dual-rail symbol encoding and decoder latency.
package hdb3_pkg;

    localparam logic [1:0] SYM_ZERO = 2'b00;
    localparam logic [1:0] SYM_N    = 2'b01;
    localparam logic [1:0] SYM_P    = 2'b10;
    localparam logic [1:0] SYM_ILL  = 2'b11;

    // Edges from sampling a line symbol to its NRZ bit on o_data.
    localparam int DEC_LATENCY = 6;

    // True for a single mark of either polarity (not space, not illegal).
    function automatic logic is_mark(input logic [1:0] sym);
        return (sym == SYM_P) || (sym == SYM_N);
    endfunction

endpackage

// File: rtl/hdb3_err_cnt.sv
// Saturating line-error counter; a synchronous clear overrides a coincident error.
module hdb3_err_cnt
    import hdb3_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_err,
    input  logic                 i_clr,
    output logic [ERR_CNT_W-1:0] o_cnt
);

    localparam logic [ERR_CNT_W-1:0] CNT_ONE = 1;

    logic [ERR_CNT_W-1:0] cnt_q;
    logic [ERR_CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise add one per error cycle until all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_err && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/hdb3_decoder.sv
// HDB3 receive decoder: finds V marks by polarity repetition, strips V and its
// B companion from a 4-deep shift line, and flags line-code errors.
module hdb3_decoder
    import hdb3_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_p,
    input  logic                 i_n,
    input  logic                 i_clr_cnt,
    output logic                 o_data,
    output logic                 o_lock,
    output logic                 o_cv_err,
    output logic                 o_zero_err,
    output logic                 o_illegal,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    // Stage 0: raw symbol. Stage 1: classified bit and V flag. Then shift line.
    logic [1:0] sym_q,    sym_d;
    logic       bit_q,    bit_d;
    logic       vflag_q,  vflag_d;
    logic [3:0] sr_q,     sr_d;
    logic       data_q,   data_d;
    // Line state: last mark polarity (1 = P), last V polarity, mark history.
    logic       last_p_q, last_p_d;
    logic       v_seen_q, v_seen_d;
    logic       v_pol_q,  v_pol_d;
    logic [1:0] hist_q,   hist_d;
    logic [2:0] zcnt_q,   zcnt_d;
    logic       lock_q,   lock_d;
    logic       cv_q,     cv_d;
    logic       zero_q,   zero_d;
    logic       ill_q,    ill_d;

    logic       mark;
    logic       sym_p;
    logic       is_v;

    // Classify the registered symbol and compute all next-state values.
    always_comb begin
        mark     = is_mark(sym_q);
        sym_p    = (sym_q == SYM_P);
        is_v     = mark && (sym_p == last_p_q);

        sym_d    = {i_p, i_n};
        bit_d    = mark && !is_v;
        vflag_d  = is_v;
        last_p_d = (mark && !is_v) ? sym_p : last_p_q;
        v_seen_d = v_seen_q | is_v;
        v_pol_d  = is_v ? sym_p : v_pol_q;
        hist_d   = {hist_q[0], mark};
        lock_d   = lock_q | mark;
        ill_d    = (sym_q == SYM_ILL);

        // A V wipes the three bits ahead of it (B slot included) and enters as 0.
        if (vflag_q) begin
            sr_d = 4'b0000;
        end else begin
            sr_d = {sr_q[2:0], bit_q};
        end
        data_d = sr_q[3];

        // Legal V must follow two spaces and alternate polarity with the prior V.
        cv_d = is_v && (hist_q[0] || hist_q[1] || (v_seen_q && (v_pol_q == sym_p)));

        zcnt_d = zcnt_q;
        if (mark) begin
            zcnt_d = 3'd0;
        end else if (zcnt_q != 3'd4) begin
            zcnt_d = zcnt_q + 3'd1;
        end
        zero_d = !mark && (zcnt_q == 3'd3) && lock_q;
    end

    // Pipeline, line state and registered error pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sym_q    <= SYM_ZERO;
            bit_q    <= 1'b0;
            vflag_q  <= 1'b0;
            sr_q     <= 4'b0000;
            data_q   <= 1'b0;
            last_p_q <= 1'b0;
            v_seen_q <= 1'b0;
            v_pol_q  <= 1'b0;
            hist_q   <= 2'b00;
            zcnt_q   <= 3'd0;
            lock_q   <= 1'b0;
            cv_q     <= 1'b0;
            zero_q   <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            sym_q    <= sym_d;
            bit_q    <= bit_d;
            vflag_q  <= vflag_d;
            sr_q     <= sr_d;
            data_q   <= data_d;
            last_p_q <= last_p_d;
            v_seen_q <= v_seen_d;
            v_pol_q  <= v_pol_d;
            hist_q   <= hist_d;
            zcnt_q   <= zcnt_d;
            lock_q   <= lock_d;
            cv_q     <= cv_d;
            zero_q   <= zero_d;
            ill_q    <= ill_d;
        end
    end

    hdb3_err_cnt #(
        .ERR_CNT_W (ERR_CNT_W)
    ) u_err_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_err (cv_q | zero_q | ill_q),
        .i_clr (i_clr_cnt),
        .o_cnt (o_err_cnt)
    );

    assign o_data     = data_q;
    assign o_lock     = lock_q;
    assign o_cv_err   = cv_q;
    assign o_zero_err = zero_q;
    assign o_illegal  = ill_q;

endmodule

// File: tb/tb_hdb3_decoder.sv
// Directed bench for hdb3_decoder with an expected-response scoreboard.
module tb_hdb3_decoder;
    import hdb3_pkg::*;

    localparam int CW = 4;
    localparam logic [1:0] Z = SYM_ZERO;
    localparam logic [1:0] P = SYM_P;
    localparam logic [1:0] N = SYM_N;
    localparam logic [1:0] X = SYM_ILL;

    logic          clk = 1'b0;
    logic          rst;
    logic          p_in, n_in, clr;
    logic          o_data, o_lock, o_cv_err, o_zero_err, o_illegal;
    logic [CW-1:0] o_err_cnt;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        int   k;
        logic d;
        logic [2:0] flags;
    } exp_t;

    exp_t err_q[$];
    exp_t data_q[$];

    hdb3_decoder #(.ERR_CNT_W(CW)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_p        (p_in),
        .i_n        (n_in),
        .i_clr_cnt  (clr),
        .o_data     (o_data),
        .o_lock     (o_lock),
        .o_cv_err   (o_cv_err),
        .o_zero_err (o_zero_err),
        .o_illegal  (o_illegal),
        .o_err_cnt  (o_err_cnt)
    );

    // Clock and edge counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Drive one symbol; flags = {cv, zero, illegal} expected one edge after classification.
    task automatic s(input logic [1:0] sym, input logic d, input logic [2:0] flags = 3'b000,
                     input logic c = 1'b0);
        exp_t e;
        @(negedge clk);
        {p_in, n_in} = sym;
        clr = c;
        e.k = cyc + 1;
        e.d = d;
        e.flags = flags;
        err_q.push_back(e);
        data_q.push_back(e);
    endtask

    // Monitor: error flags one edge after classification, data DEC_LATENCY edges after sampling.
    always @(negedge clk) begin
        while (err_q.size() > 0 && err_q[0].k + 1 <= cyc) begin
            exp_t e;
            e = err_q.pop_front();
            check($sformatf("err_flags k=%0d", e.k), {o_cv_err, o_zero_err, o_illegal}, e.flags);
        end
        while (data_q.size() > 0 && data_q[0].k + DEC_LATENCY <= cyc) begin
            exp_t e;
            e = data_q.pop_front();
            check($sformatf("data k=%0d", e.k), o_data, e.d);
        end
    end

    initial begin
        rst = 1'b1; p_in = 1'b0; n_in = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_data", o_data, 0);
        check("rst_lock", o_lock, 0);
        check("rst_flags", {o_cv_err, o_zero_err, o_illegal}, 0);
        check("rst_cnt", o_err_cnt, 0);

        // Encoder output for 1 followed by eight zeros: 000V then B00V.
        s(P, 1); s(Z, 0); s(Z, 0);
        check("lock_after_first_p", o_lock, 1);
        s(Z, 0); s(P, 0); s(N, 0); s(Z, 0); s(Z, 0); s(N, 0);

        // Alternating marks with spaces.
        s(P, 1); s(Z, 0); s(N, 1); s(Z, 0); s(P, 1); s(Z, 0); s(N, 1); s(Z, 0);

        // Two consecutive V of the same polarity.
        s(P, 1); s(Z, 0); s(Z, 0); s(Z, 0); s(P, 0);
        s(Z, 0); s(Z, 0); s(Z, 0); s(P, 0, 3'b100);

        // Zero run while locked: pulse on the fourth space only.
        s(N, 1); s(Z, 0); s(Z, 0);
        check("cnt_after_cv", o_err_cnt, 1);
        s(Z, 0); s(Z, 0, 3'b010); s(Z, 0); s(Z, 0); s(Z, 0);
        check("cnt_after_zero", o_err_cnt, 2);

        // Illegal symbol with the counter clear landing on the error cycle.
        s(X, 0, 3'b001); s(Z, 0); s(Z, 0, 3'b000, 1'b1); s(Z, 0);
        check("cnt_clear_wins", o_err_cnt, 0);

        // Saturation: 2^CW + 3 illegal symbols.
        for (int i = 0; i < (1 << CW) + 3; i++) s(X, 0, 3'b001);
        s(Z, 0); s(Z, 0); s(Z, 0);
        check("cnt_saturated", o_err_cnt, (1 << CW) - 1);

        // Marks in flight, then asynchronous reset between edges.
        for (int i = 0; i < 4; i++) begin
            s(P, 1); s(N, 1);
        end
        @(posedge clk);
        #2;
        rst = 1'b1; p_in = 1'b0; n_in = 1'b0;
        err_q.delete();
        data_q.delete();
        #1;
        check("arst_data", o_data, 0);
        check("arst_lock", o_lock, 0);
        check("arst_flags", {o_cv_err, o_zero_err, o_illegal}, 0);
        check("arst_cnt", o_err_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        // After reset: P is normal, second P is a V right after a mark.
        s(P, 0); s(P, 0, 3'b100);
        s(Z, 0); s(Z, 0); s(Z, 0); s(Z, 0, 3'b010);
        for (int i = 0; i < 6; i++) s(Z, 0);

        for (int i = 0; i < 20 && (err_q.size() > 0 || data_q.size() > 0); i++) @(negedge clk);
        check("drain_err_q", err_q.size(), 0);
        check("drain_data_q", data_q.size(), 0);
        check("cnt_final", o_err_cnt, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hdb3_decoder.md
Name: hdb3_decoder

Overview:
- Receive-side HDB3 line decoder. It sits directly downstream of the HDB3 encoder, or of the line interface that carries its output.
- Consumes the dual-rail line symbol (i_p/i_n, one symbol per clock) and detects violation (V) marks by polarity repetition. Removes each V and its companion B substitution, and recovers the NRZ data stream at fixed latency.
- Also flags line-code errors and keeps a saturating error count for link monitoring.

Parameters:
- ERR_CNT_W, 16, width of the saturating line-error counter.

Ports:
- i_clk  input  1  system clock; one line symbol per rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_p  input  1  positive mark of the line symbol.
- i_n  input  1  negative mark of the line symbol.
- i_clr_cnt  input  1  synchronous clear of o_err_cnt.
- o_data  output  1  decoded NRZ bit.
- o_lock  output  1  high once the first mark has been received.
- o_cv_err  output  1  one-cycle pulse: code violation error.
- o_zero_err  output  1  one-cycle pulse: four consecutive spaces while locked.
- o_illegal  output  1  one-cycle pulse: i_p and i_n both high.
- o_err_cnt  output  ERR_CNT_W  saturating count of all error pulses.

Behaviour:
- Reset: every output is 0 and o_err_cnt is 0.
  - Last-mark polarity resets to N, so the first P is a normal mark; this matches the encoder's initial polarity.
  - Last-V polarity is "unknown": v_seen=0.
  - Shift line and zero-run counter reset to 0.
- Symbol classes: P = 10, N = 01, space = 00, illegal = 11.
- Stage 0: register i_p/i_n into r_sym.
- Stage 1, classification of r_sym:
  - Mark with polarity opposite to last mark: normal 1. Shift 1 into sr[0] and update last-mark polarity.
  - Mark with polarity equal to last mark: V.
    - Shift 0 into sr[0].
    - Clear the three previously shifted bits, which become sr[3:1] after the shift. This removes B when present.
    - Last-mark polarity is unchanged.
    - Record V polarity and set v_seen.
  - Space: shift 0.
  - Illegal: shift 0, leave polarity unchanged, pulse o_illegal.
- Shift line sr[3:0] is 4 deep; o_data is registered from sr[3].
- Latency: a symbol sampled at edge k appears on o_data after edge k+6. This is fixed and holds independent of V/B activity.
- A V clears positions already in the line; bits at sr[3] on the same edge have already left and are unaffected.
- o_cv_err pulses 1 cycle after the V is classified, in either of these cases:
  - Either of the two symbols immediately preceding V was a mark, i.e. not of the form x00V.
  - v_seen=1 and V polarity equals the previous V polarity.
- o_zero_err:
  - The zero-run counter increments on space/illegal, saturates at 4, and clears on any mark.
  - The pulse fires only on the transition to 4, and only while o_lock=1.
- o_lock is set by the first mark after reset and stays set until reset.
- o_err_cnt:
  - Increments by 1 per cycle in which any of o_cv_err, o_zero_err or o_illegal is high. Simultaneous errors still add 1.
  - Saturates at all-ones and never wraps.
  - When i_clr_cnt coincides with an error, clear wins and the count is 0.
- Reset mid-stream: all state returns to reset values immediately. Symbols in flight are discarded and o_data is 0.

Decomposition:
- hdb3_pkg holds the symbol encoding constants (SYM_ZERO=00, SYM_N=01, SYM_P=10, SYM_ILL=11) and the decoder pipeline latency constant (6). These are shared with the encoder and its bench.
- One sub-module, hdb3_err_cnt: saturating counter with synchronous clear. Parameterised by ERR_CNT_W; takes an error pulse and i_clr_cnt.

Test Plan:
- Line P,0,0,0,P,N,0,0,N (encoder output for data 1,0,0,0,0,0,0,0,0) -> o_data = 1,0,0,0,0,0,0,0,0, starting 6 cycles after the first symbol; no error pulses; o_lock high from the first P.
- Alternating marks P,N,P,N with spaces between -> every mark decodes as 1; no errors; latency exactly 6.
- Line P,0,0,0,P,0,0,0,P -> the second V has the same polarity as the first V -> o_cv_err pulses once; o_err_cnt = 1; both V decode as 0.
- After lock, line P,0,0,0,0 -> o_zero_err pulses on the fourth space only; a fifth space gives no further pulse.
- Symbol 11 injected, together with i_clr_cnt on the same cycle the error counts -> o_illegal pulses; the illegal symbol decodes as 0; o_err_cnt reads 0.
- Force 2^ERR_CNT_W+3 illegal symbols -> o_err_cnt holds all-ones; assert i_rst mid-stream -> all outputs 0 asynchronously, o_lock 0.
